// File: rtl/nnet_argmax_reducer.sv
// nnet_argmax_reducer
// Reduces one score vector (VEC_LEN beats) from the NN core to a single
// classification beat {argmax index, max score} with tlast set.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clear               synchronous clear (same effect as reset)
//   set_stb/addr/data   settings bus (threshold register only)
//   i_t*                score stream in, score in i_tdata[2*WIDTH-1:WIDTH]
//   o_t*                one-beat result stream out, {index, max_score}
//   err_short           sticky: vector ended on i_tlast before VEC_LEN beats
//   err_long            sticky: VEC_LEN beats arrived without i_tlast
//
// Optional feature macro: NNET_ARGMAX_THRESH_EN
//   When defined, a settings write to SR_THRESH loads a signed threshold;
//   results whose max score is below it report index all-ones (reject).

module nnet_argmax_reducer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned VEC_LEN   = 10,
  parameter int unsigned SR_THRESH = 200
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               set_stb,
  input  logic [7:0]         set_addr,
  input  logic [31:0]        set_data,
  input  logic [2*WIDTH-1:0] i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [2*WIDTH-1:0] o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic               err_short,
  output logic               err_long
);

  localparam int unsigned DATA_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]         count_q;
  logic signed [WIDTH-1:0]  max_q;
  logic [WIDTH-1:0]         idx_q;

  logic signed [WIDTH-1:0]  score;
  logic                     beat_acc;
  logic                     take_new;
  logic                     last_cnt;
  logic                     end_beat;
  logic signed [WIDTH-1:0]  max_nx;
  logic [WIDTH-1:0]         idx_nx;
  logic [WIDTH-1:0]         res_idx;

  // Score lives in the upper half of the input word
  assign score    = i_tdata[DATA_W-1:WIDTH];
  assign beat_acc = i_tvalid & i_tready;
  assign last_cnt = (count_q == LAST_CNT);
  assign end_beat = i_tlast | last_cnt;

  // Running argmax including the current beat; strict compare keeps the
  // lowest index on ties, and the first beat always loads
  assign take_new = (count_q == '0) || (score > max_q);
  assign max_nx   = take_new ? score : max_q;
  assign idx_nx   = take_new ? WIDTH'(count_q) : idx_q;

`ifdef NNET_ARGMAX_THRESH_EN
  logic signed [WIDTH-1:0] thresh_q;
  logic                    unused_bits;

  // Threshold register, written from the settings bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thresh_q <= MOST_NEG;
    end else if (clear) begin
      thresh_q <= MOST_NEG;
    end else if (set_stb && (set_addr == 8'(SR_THRESH))) begin
      thresh_q <= WIDTH'(set_data);
    end
  end

  // Scores below threshold report the reject class (all ones)
  assign res_idx     = (max_nx < thresh_q) ? '1 : idx_nx;
  assign unused_bits = ^{i_tdata[WIDTH-1:0], set_data};
`else
  logic unused_bits;

  assign res_idx     = idx_nx;
  assign unused_bits = ^{i_tdata[WIDTH-1:0], set_stb, set_addr, set_data};
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACCUM;
    end else if (clear) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:  if (beat_acc && end_beat) state_d = ST_OUTPUT;
      ST_OUTPUT: if (o_tvalid && o_tready) state_d = ST_ACCUM;
      default:   state_d = ST_ACCUM;
    endcase
  end

  // State-decoded outputs; input ready depends on state only
  always_comb begin
    i_tready = 1'b0;
    if (state_q == ST_ACCUM) i_tready = 1'b1;
  end

  // Accumulator, result register and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      o_tdata   <= '0;
      o_tvalid  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (clear) begin
      count_q   <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      o_tdata   <= '0;
      o_tvalid  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (beat_acc) begin
      max_q <= max_nx;
      idx_q <= idx_nx;
      if (end_beat) begin
        count_q  <= '0;
        o_tdata  <= {res_idx, max_nx};
        o_tvalid <= 1'b1;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
      if (i_tlast && !last_cnt) err_short <= 1'b1;
      if (last_cnt && !i_tlast) err_long  <= 1'b1;
    end else if (o_tvalid && o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  // Every result is a single-beat packet
  assign o_tlast = o_tvalid;

endmodule

// File: tb/tb_nnet_argmax_reducer.sv
module tb_nnet_argmax_reducer;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned VEC_LEN = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        err_short;
  logic        err_long;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] s[4];
    int          n;
    bit          last;
    logic [15:0] e_idx;
    logic [15:0] e_max;
    bit          e_short;
    bit          e_long;
  } vec_t;

  vec_t tab[8];

  nnet_argmax_reducer #(
    .WIDTH(WIDTH),
    .VEC_LEN(VEC_LEN),
    .SR_THRESH(200)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .set_stb(set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .i_tdata(i_tdata),
    .i_tlast(i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .err_short(err_short),
    .err_long(err_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: pop and compare on every output handshake
  always @(negedge clk) begin
    if (reset_n && o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", o_tdata);
      end else begin
        chk("result_tdata", o_tdata, exp_q.pop_front());
      end
      chk("result_tlast", {31'd0, o_tlast}, 32'd1);
    end
  end

  task automatic send_beat(input logic [15:0] s, input bit last);
    bit acc;
    int n;
    n        = 0;
    i_tdata  = {s, 16'hA5A5};
    i_tlast  = last;
    i_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL beat_accept_timeout actual=not_accepted required=accepted");
        break;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input string tag);
    exp_q.push_back({v.e_idx, v.e_max});
    for (int i = 0; i < v.n; i++) send_beat(v.s[i], v.last && (i == v.n - 1));
    chk({tag, "_ovalid_latency"}, {31'd0, o_tvalid}, 32'd1);
    chk({tag, "_itready_low"}, {31'd0, i_tready}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic set_write(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tab[0] = '{s:'{16'h0003, 16'hFFFE, 16'h0007, 16'h0005}, n:4, last:1'b1,
               e_idx:16'h0002, e_max:16'h0007, e_short:1'b0, e_long:1'b0};
    tab[1] = '{s:'{16'h0005, 16'h0005, 16'h0001, 16'h0005}, n:4, last:1'b1,
               e_idx:16'h0000, e_max:16'h0005, e_short:1'b0, e_long:1'b0};
    tab[2] = '{s:'{16'h8000, 16'h8000, 16'h8000, 16'h8000}, n:4, last:1'b1,
               e_idx:16'h0000, e_max:16'h8000, e_short:1'b0, e_long:1'b0};
    tab[3] = '{s:'{16'hFFFF, 16'h0004, 16'h0000, 16'h0000}, n:2, last:1'b1,
               e_idx:16'h0001, e_max:16'h0004, e_short:1'b1, e_long:1'b0};
    tab[4] = '{s:'{16'h0000, 16'h0000, 16'h0009, 16'h0000}, n:4, last:1'b0,
               e_idx:16'h0002, e_max:16'h0009, e_short:1'b0, e_long:1'b1};
    tab[5] = '{s:'{16'h002A, 16'h0000, 16'h0000, 16'h0000}, n:1, last:1'b1,
               e_idx:16'h0000, e_max:16'h002A, e_short:1'b1, e_long:1'b0};
    tab[6] = '{s:'{16'hFFFB, 16'hFFFD, 16'hFFFD, 16'hFFF7}, n:4, last:1'b1,
               e_idx:16'h0001, e_max:16'hFFFD, e_short:1'b0, e_long:1'b0};
    tab[7] = '{s:'{16'h0001, 16'h0002, 16'h0003, 16'h0004}, n:4, last:1'b1,
               e_idx:16'h0003, e_max:16'h0004, e_short:1'b0, e_long:1'b0};

    reset_n  = 1'b0;
    clear    = 1'b0;
    set_stb  = 1'b0;
    set_addr = 8'd0;
    set_data = 32'd0;
    i_tdata  = 32'd0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ovalid", {31'd0, o_tvalid}, 32'd0);
    chk("reset_otlast", {31'd0, o_tlast}, 32'd0);
    chk("reset_otdata", o_tdata, 32'd0);
    chk("reset_err_short", {31'd0, err_short}, 32'd0);
    chk("reset_err_long", {31'd0, err_long}, 32'd0);
    chk("reset_itready", {31'd0, i_tready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors, each from a clean error state
    for (int r = 0; r < 8; r++) begin
      do_clear();
      send_vec(tab[r], $sformatf("row%0d", r));
      drain();
      chk($sformatf("row%0d_err_short", r), {31'd0, err_short}, {31'd0, tab[r].e_short});
      chk($sformatf("row%0d_err_long", r), {31'd0, err_long}, {31'd0, tab[r].e_long});
    end

    // Sticky flags accumulate, then clear drops both
    do_clear();
    send_vec(tab[3], "sticky_a");
    send_vec(tab[4], "sticky_b");
    drain();
    chk("sticky_err_short", {31'd0, err_short}, 32'd1);
    chk("sticky_err_long", {31'd0, err_long}, 32'd1);
    do_clear();
    chk("clear_err_short", {31'd0, err_short}, 32'd0);
    chk("clear_err_long", {31'd0, err_long}, 32'd0);

    // Backpressure: result held 20 cycles, next vector waits, nothing lost
    o_tready = 1'b0;
    send_vec(tab[0], "bp_first");
    fork
      send_vec(tab[7], "bp_second");
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          chk("bp_hold_tdata", o_tdata, 32'h0002_0007);
          chk("bp_hold_ovalid", {31'd0, o_tvalid}, 32'd1);
          chk("bp_hold_itready", {31'd0, i_tready}, 32'd0);
        end
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        @(negedge clk);
        chk("bp_release_itready_same", {31'd0, i_tready}, 32'd0);
        @(negedge clk);
        chk("bp_release_itready_next", {31'd0, i_tready}, 32'd1);
      end
    join
    drain();

    // Reset with a pending result drops o_tvalid asynchronously
    o_tready = 1'b0;
    send_vec(tab[1], "rst_pending");
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_ovalid", {31'd0, o_tvalid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n  = 1'b1;
    o_tready = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-vector discards the partial vector
    send_beat(16'h0009, 1'b0);
    send_beat(16'h0008, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ovalid", {31'd0, o_tvalid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{s:'{16'h0001, 16'h0002, 16'h0003, 16'h0000}, n:4, last:1'b1,
          e_idx:16'h0002, e_max:16'h0003, e_short:1'b0, e_long:1'b0};
    send_vec(v, "rst_mid_after");
    drain();

    // Clear discards a pending result
    o_tready = 1'b0;
    send_vec(tab[0], "clr_pending");
    do_clear();
    chk("clr_pending_ovalid", {31'd0, o_tvalid}, 32'd0);
    chk("clr_pending_itready", {31'd0, i_tready}, 32'd1);
    exp_q.delete();
    o_tready = 1'b1;

`ifdef NNET_ARGMAX_THRESH_EN
    set_write(8'd200, 32'd10);
    set_write(8'd201, 32'd0);
    v = '{s:'{16'h0003, 16'h0009, 16'h0001, 16'h0002}, n:4, last:1'b1,
          e_idx:16'hFFFF, e_max:16'h0009, e_short:1'b0, e_long:1'b0};
    send_vec(v, "thr_reject");
    drain();
    v = '{s:'{16'h0003, 16'h000C, 16'h0001, 16'h0002}, n:4, last:1'b1,
          e_idx:16'h0001, e_max:16'h000C, e_short:1'b0, e_long:1'b0};
    send_vec(v, "thr_pass");
    drain();
    do_clear();
    v = '{s:'{16'h0003, 16'h0009, 16'h0001, 16'h0002}, n:4, last:1'b1,
          e_idx:16'h0001, e_max:16'h0009, e_short:1'b0, e_long:1'b0};
    send_vec(v, "thr_cleared");
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nnet_argmax_reducer.md
Name: nnet_argmax_reducer

Overview:
- Sits between the HLS neural-net core output and the vector wrapper's s_axis_data input.
- Consumes one score vector of VEC_LEN beats from the network and emits a single classification beat per vector, carrying the argmax index and the max score.
- Beat, index and vector-length boundaries are enforced here, so the downstream packet resizer always sees one well-formed, tlast-terminated beat per vector.

Parameters:
- WIDTH, 16, score width; tdata is 2*WIDTH.
- VEC_LEN, 10, number of scores per vector (2..2^WIDTH-1).
- SR_THRESH, 200, settings-bus address of the threshold register (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear, same effect as reset
- set_stb  in  1  settings strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  2*WIDTH  score in [2*WIDTH-1:WIDTH], signed; low half ignored
- i_tlast  in  1  end of vector from the NN core
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  2*WIDTH  {index[WIDTH-1:0], max_score[WIDTH-1:0]}
- o_tlast  out  1  always equals o_tvalid (one-beat packets)
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- err_short  out  1  sticky: a vector ended on i_tlast before VEC_LEN beats
- err_long  out  1  sticky: VEC_LEN beats arrived without i_tlast

Behaviour:
- Reset or clear values: state=ACCUM, count=0, max=0, idx=0, o_tvalid=0, o_tdata=0, o_tlast=0, err_short=0, err_long=0, threshold=most-negative signed value.
- Reset is asynchronous on the falling edge of reset_n and released synchronously. clear takes effect on the next edge and discards any partial vector and any pending output.
- i_tready = (state==ACCUM). It is combinational from state only; there is no path from o_tready to i_tready.
- ACCUM, on each accepted beat (i_tvalid & i_tready):
  - If count==0, or score > max (signed, strict compare), load max<=score and idx<=count. Ties keep the lowest index.
  - end = i_tlast | (count==VEC_LEN-1).
  - If end: go to OUTPUT; count<=0; register o_tdata from the updated max and idx, including the current beat; o_tvalid<=1.
  - If i_tlast and count<VEC_LEN-1: set err_short.
  - If count==VEC_LEN-1 and !i_tlast: set err_long. The next beat starts a new vector; no resync.
  - Otherwise count<=count+1.
- OUTPUT: hold o_tdata/o_tvalid stable until o_tready. On o_tvalid & o_tready: o_tvalid<=0, state<=ACCUM. The next input beat is accepted on the following cycle.
- Latency: o_tvalid rises 1 cycle after the last input beat is accepted. Minimum throughput is VEC_LEN+1 cycles per vector.
- A single-beat vector (i_tlast on the first beat) outputs index 0 and that score, and sets err_short.
- Sticky error flags are cleared only by reset_n or clear.
- Settings writes to addresses other than SR_THRESH are ignored.

Optional Feature:
- Macro NNET_ARGMAX_THRESH_EN.
- Defined:
  - set_stb & set_addr==SR_THRESH loads threshold<=set_data[WIDTH-1:0] (signed).
  - At output time, if max < threshold, the index field is forced to all ones (reject class); the max_score field is unchanged.
  - A threshold write during a vector applies to that vector's result if it lands before the end-beat register update.
- Not defined: no threshold register, settings ports unused, index is always the argmax.

Test Plan:
- VEC_LEN=4, scores 3,-2,7,5 with i_tlast on beat 4, o_tready=1 -> one beat, o_tdata={16'd2,16'd7}, o_tlast=1, o_tvalid 1 cycle after beat 4, no error flags.
- Scores 5,5,1,5 -> index 0 (tie keeps first); all scores -32768 -> index 0, score 16'h8000.
- i_tlast on beat 2 with scores -1,4 -> {1,4}, err_short=1; then 4 beats with no tlast and scores 0,0,9,0 -> {2,9}, err_long=1; a following clear -> both flags 0.
- o_tready held low 20 cycles after result -> o_tdata stable, i_tready=0 throughout, no input lost; release -> next vector accepted on the following cycle.
- reset_n pulsed low mid-vector (after 2 beats) -> o_tvalid=0 immediately; next 4 beats 1,2,3,0 -> {2,3}.
- With NNET_ARGMAX_THRESH_EN and threshold=10: scores 3,9,1,2 -> index 16'hFFFF, score 9; scores 3,12,1,2 -> {1,12}.
